// File: rtl/risc_core_param.sv
// Parametrised accumulator CPU: two-word instruction fetch, 8-opcode ISA,
// memory request/ready handshake with wait states, carry flag and halt/resume.
module risc_core_param #(
  parameter int unsigned         DATA_W   = 8,
  parameter logic [2*DATA_W-4:0] RESET_PC = '0
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  input  logic                resume,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [2*DATA_W-4:0] mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                halt,
  output logic                zero,
  output logic                carry,
  output logic                fetch,
  output logic [2:0]          opcode,
  output logic [2*DATA_W-4:0] ir_addr,
  output logic [2*DATA_W-4:0] pc_addr
);
  localparam int unsigned ADDR_W = 2*DATA_W-3;
  localparam int unsigned IR_W   = 2*DATA_W;

  typedef enum logic [2:0] {S_F0, S_F1, S_EX, S_MR, S_MW, S_HALT} state_e;
  typedef enum logic [2:0] {
    OP_HLT = 3'd0, OP_SKZ = 3'd1, OP_ADD = 3'd2, OP_AND = 3'd3,
    OP_XOR = 3'd4, OP_LDA = 3'd5, OP_STO = 3'd6, OP_JMP = 3'd7
  } op_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic              carry_q, carry_d;
  op_e               op;
  logic [DATA_W:0]   sum;

  assign op  = op_e'(ir_q[IR_W-1 -: 3]);
  assign sum = {1'b0, acc_q} + {1'b0, mem_rdata};

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= S_F0;
      pc_q    <= RESET_PC;
      acc_q   <= '0;
      ir_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    ir_d    = ir_q;
    carry_d = carry_q;
    unique case (state_q)
      S_F0: if (mem_ready) begin
        ir_d[IR_W-1:DATA_W] = mem_rdata;
        pc_d                = pc_q + ADDR_W'(1);
        state_d             = S_F1;
      end
      S_F1: if (mem_ready) begin
        ir_d[DATA_W-1:0] = mem_rdata;
        pc_d             = pc_q + ADDR_W'(1);
        state_d          = S_EX;
      end
      S_EX: begin
        case (op)
          OP_HLT: state_d = S_HALT;
          OP_SKZ: begin
            if (acc_q == '0) pc_d = pc_q + ADDR_W'(2);
            state_d = S_F0;
          end
          OP_JMP: begin
            pc_d    = ir_q[ADDR_W-1:0];
            state_d = S_F0;
          end
          OP_STO:  state_d = S_MW;
          default: state_d = S_MR;
        endcase
      end
      S_MR: if (mem_ready) begin
        case (op)
          OP_ADD:  {carry_d, acc_d} = sum;
          OP_AND:  acc_d = acc_q & mem_rdata;
          OP_XOR:  acc_d = acc_q ^ mem_rdata;
          OP_LDA:  acc_d = mem_rdata;
          default: acc_d = acc_q;
        endcase
        state_d = S_F0;
      end
      S_MW:    if (mem_ready) state_d = S_F0;
      S_HALT:  if (resume) state_d = S_F0;
      default: state_d = S_F0;
    endcase
  end

  // Requests are Moore outputs of the state, but reset masks them immediately.
  always_comb begin
    mem_rd    = (state_q == S_F0 || state_q == S_F1 || state_q == S_MR) && !rst;
    mem_wr    = (state_q == S_MW) && !rst;
    mem_addr  = (state_q == S_MR || state_q == S_MW) ? ir_q[ADDR_W-1:0] : pc_q;
    mem_wdata = mem_wr ? acc_q : '0;
    halt      = (state_q == S_HALT);
    fetch     = (state_q == S_F0 || state_q == S_F1);
  end

  assign zero    = (acc_q == '0);
  assign carry   = carry_q;
  assign opcode  = ir_q[IR_W-1 -: 3];
  assign ir_addr = ir_q[ADDR_W-1:0];
  assign pc_addr = pc_q;

endmodule
